// File: rtl/cam_access_scheduler.sv
// ---------------------------------------------------------------------------
// cam_access_scheduler
//
// Purpose:
//   Shares the single CAM command port between the merged lookup stream and
//   the merged update stream.
//   - Updates normally win arbitration.
//   - A starvation counter guarantees that a waiting lookup eventually gets
//     the port.
//   - Lookups in flight (accepted but not yet answered) are counted and
//     capped.
//   - A flush request stops new accepts, waits for all in-flight work to
//     drain, and then pulses flush_done.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   s_lookup_index/user/valid    lookup request in
//   s_lookup_ready               lookup request accepted (combinational grant)
//   s_update_index/data/user/valid  update request in
//   s_update_ready               update request accepted (combinational grant)
//   m_cmd_op/index/data/user     registered CAM command (op 0 = lookup, 1 = update)
//   m_cmd_valid, m_cmd_ready     CAM command handshake
//   rsp_fire                     one lookup result returned by the CAM
//   flush_req                    request to drain all in-flight work
//   flush_done                   one-cycle pulse when the drain is complete
//   outstanding                  number of lookups in flight
// ---------------------------------------------------------------------------
module cam_access_scheduler #(
    parameter int KEY_SIZE        = 8,
    parameter int VALUE_SIZE      = 32,
    parameter int USER_WIDTH      = 4,
    parameter int STARVE_LIMIT    = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [KEY_SIZE-1:0]                    s_lookup_index,
    input  logic [USER_WIDTH-1:0]                  s_lookup_user,
    input  logic                                   s_lookup_valid,
    output logic                                   s_lookup_ready,
    input  logic [KEY_SIZE-1:0]                    s_update_index,
    input  logic [VALUE_SIZE-1:0]                  s_update_data,
    input  logic [USER_WIDTH-1:0]                  s_update_user,
    input  logic                                   s_update_valid,
    output logic                                   s_update_ready,
    output logic                                   m_cmd_op,
    output logic [KEY_SIZE-1:0]                    m_cmd_index,
    output logic [VALUE_SIZE-1:0]                  m_cmd_data,
    output logic [USER_WIDTH-1:0]                  m_cmd_user,
    output logic                                   m_cmd_valid,
    input  logic                                   m_cmd_ready,
    input  logic                                   rsp_fire,
    input  logic                                   flush_req,
    output logic                                   flush_done,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding
);

    localparam int OUT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [OUT_W-1:0]    OUT_MAX    = OUT_W'(MAX_OUTSTANDING);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [STARVE_W-1:0] starve_cnt;

    logic slot_free;
    logic l_elig;
    logic u_elig;
    logic grant_lookup;
    logic grant_update;
    logic rsp_take;

    // Arbitration. The eligibility check deliberately uses the registered
    // outstanding count, so a response arriving this cycle does not free a
    // lookup slot until the next cycle.
    always_comb begin
        slot_free    = !m_cmd_valid || m_cmd_ready;
        l_elig       = s_lookup_valid && (outstanding < OUT_MAX);
        u_elig       = s_update_valid;
        grant_lookup = 1'b0;
        grant_update = 1'b0;
        if (state == RUN && slot_free) begin
            if (l_elig && (!u_elig || starve_cnt == STARVE_MAX)) begin
                grant_lookup = 1'b1;
            end else if (u_elig) begin
                grant_update = 1'b1;
            end
        end
        // A response when nothing is in flight is spurious and ignored.
        rsp_take = rsp_fire && (outstanding != '0);
    end

    assign s_lookup_ready = grant_lookup;
    assign s_update_ready = grant_update;

    // Single output register stage; the payload only moves when the slot is
    // free, which keeps it stable while the CAM back-pressures.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_cmd_valid <= 1'b0;
            m_cmd_op    <= 1'b0;
            m_cmd_index <= '0;
            m_cmd_data  <= '0;
            m_cmd_user  <= '0;
        end else if (slot_free) begin
            m_cmd_valid <= grant_lookup || grant_update;
            if (grant_lookup) begin
                m_cmd_op    <= 1'b0;
                m_cmd_index <= s_lookup_index;
                m_cmd_data  <= '0;
                m_cmd_user  <= s_lookup_user;
            end else if (grant_update) begin
                m_cmd_op    <= 1'b1;
                m_cmd_index <= s_update_index;
                m_cmd_data  <= s_update_data;
                m_cmd_user  <= s_update_user;
            end
        end
    end

    // Starvation counter: counts update wins against an eligible lookup and
    // forgets its history as soon as the lookup wins or stops being eligible.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_lookup || !l_elig) begin
            starve_cnt <= '0;
        end else if (grant_update && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

    // In-flight lookup counter; accept and response in one cycle cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({grant_lookup, rsp_take})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Flush sequencing. DRAIN blocks new grants; the registered command and
    // all in-flight lookups must be gone before DONE pulses flush_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                RUN: begin
                    if (flush_req) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!m_cmd_valid && outstanding == '0) begin
                        state      <= DONE;
                        flush_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_access_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cam_access_scheduler
//
// Purpose:
//   Self-checking bench for cam_access_scheduler. Directed scenarios check
//   arbitration order, the in-flight cap, back-pressure, flush sequencing,
//   reset and response underflow; a randomized run compares every cycle
//   against a behavioural model of the scheduling rules.
// ---------------------------------------------------------------------------
module tb_cam_access_scheduler;

    localparam int KEY_SIZE        = 8;
    localparam int VALUE_SIZE      = 32;
    localparam int USER_WIDTH      = 4;
    localparam int STARVE_LIMIT    = 4;
    localparam int MAX_OUTSTANDING = 4;
    localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1);

    logic                  clk;
    logic                  rst;
    logic [KEY_SIZE-1:0]   s_lookup_index;
    logic [USER_WIDTH-1:0] s_lookup_user;
    logic                  s_lookup_valid;
    logic                  s_lookup_ready;
    logic [KEY_SIZE-1:0]   s_update_index;
    logic [VALUE_SIZE-1:0] s_update_data;
    logic [USER_WIDTH-1:0] s_update_user;
    logic                  s_update_valid;
    logic                  s_update_ready;
    logic                  m_cmd_op;
    logic [KEY_SIZE-1:0]   m_cmd_index;
    logic [VALUE_SIZE-1:0] m_cmd_data;
    logic [USER_WIDTH-1:0] m_cmd_user;
    logic                  m_cmd_valid;
    logic                  m_cmd_ready;
    logic                  rsp_fire;
    logic                  flush_req;
    logic                  flush_done;
    logic [OUT_W-1:0]      outstanding;

    int total;
    int bad;

    cam_access_scheduler #(
        .KEY_SIZE       (KEY_SIZE),
        .VALUE_SIZE     (VALUE_SIZE),
        .USER_WIDTH     (USER_WIDTH),
        .STARVE_LIMIT   (STARVE_LIMIT),
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_lookup_index(s_lookup_index),
        .s_lookup_user (s_lookup_user),
        .s_lookup_valid(s_lookup_valid),
        .s_lookup_ready(s_lookup_ready),
        .s_update_index(s_update_index),
        .s_update_data (s_update_data),
        .s_update_user (s_update_user),
        .s_update_valid(s_update_valid),
        .s_update_ready(s_update_ready),
        .m_cmd_op      (m_cmd_op),
        .m_cmd_index   (m_cmd_index),
        .m_cmd_data    (m_cmd_data),
        .m_cmd_user    (m_cmd_user),
        .m_cmd_valid   (m_cmd_valid),
        .m_cmd_ready   (m_cmd_ready),
        .rsp_fire      (rsp_fire),
        .flush_req     (flush_req),
        .flush_done    (flush_done),
        .outstanding   (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: phase is 0 = accepting, 1 = draining, 2 = done pulse.
    int                    m_phase, n_phase;
    int                    m_starve, n_starve;
    int                    m_out, n_out;
    bit                    m_valid, n_valid;
    bit                    m_op, n_op;
    logic [KEY_SIZE-1:0]   m_index, n_index;
    logic [VALUE_SIZE-1:0] m_data, n_data;
    logic [USER_WIDTH-1:0] m_user, n_user;
    bit                    m_done, n_done;
    bit                    exp_lr, exp_ur;

    // Works out who should be granted this cycle and what every piece of
    // visible state should be after the next clock edge.
    task automatic model_eval();
        bit slot, lookup_ok, take_l, take_u;
        n_phase = m_phase; n_starve = m_starve; n_out = m_out;
        n_valid = m_valid; n_op = m_op; n_index = m_index;
        n_data = m_data; n_user = m_user; n_done = 1'b0;
        slot      = !m_valid || m_cmd_ready;
        lookup_ok = s_lookup_valid && (m_out < MAX_OUTSTANDING);
        take_l    = (m_phase == 0) && slot && lookup_ok &&
                    (!s_update_valid || m_starve == STARVE_LIMIT);
        take_u    = (m_phase == 0) && slot && s_update_valid && !take_l;
        exp_lr    = take_l;
        exp_ur    = take_u;
        if (take_l || !lookup_ok) n_starve = 0;
        else if (take_u) n_starve = (m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1;
        n_out = m_out + (take_l ? 1 : 0) - ((rsp_fire && m_out > 0) ? 1 : 0);
        if (slot) begin
            n_valid = take_l || take_u;
            if (take_l) begin
                n_op = 1'b0; n_index = s_lookup_index; n_data = '0; n_user = s_lookup_user;
            end else if (take_u) begin
                n_op = 1'b1; n_index = s_update_index; n_data = s_update_data; n_user = s_update_user;
            end
        end
        if (m_phase == 0 && flush_req) n_phase = 1;
        else if (m_phase == 1 && !m_valid && m_out == 0) begin
            n_phase = 2; n_done = 1'b1;
        end else if (m_phase == 2) n_phase = 0;
        if (rst) begin
            n_phase = 0; n_starve = 0; n_out = 0; n_valid = 1'b0; n_op = 1'b0;
            n_index = '0; n_data = '0; n_user = '0; n_done = 1'b0;
        end
    endtask

    task automatic prep();
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        m_phase = n_phase; m_starve = n_starve; m_out = n_out;
        m_valid = n_valid; m_op = n_op; m_index = n_index;
        m_data = n_data; m_user = n_user; m_done = n_done;
        #1;
    endtask

    task automatic set_idle();
        s_lookup_index = '0; s_lookup_user = '0; s_lookup_valid = 1'b0;
        s_update_index = '0; s_update_data = '0; s_update_user = '0;
        s_update_valid = 1'b0; m_cmd_ready = 1'b0; rsp_fire = 1'b0; flush_req = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        prep(); tick();
        prep(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        prep(); tick();
        total++; if (m_cmd_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0b want=0", m_cmd_valid); end
        total++; if (m_cmd_op !== 1'b0) begin bad++; $display("[TB] FAIL reset_op got=%0b want=0", m_cmd_op); end
        total++; if (m_cmd_index !== '0) begin bad++; $display("[TB] FAIL reset_index got=%0h want=0", m_cmd_index); end
        total++; if (m_cmd_data !== '0) begin bad++; $display("[TB] FAIL reset_data got=%0h want=0", m_cmd_data); end
        total++; if (m_cmd_user !== '0) begin bad++; $display("[TB] FAIL reset_user got=%0h want=0", m_cmd_user); end
        total++; if (flush_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_flush_done got=%0b want=0", flush_done); end
        total++; if (outstanding !== '0) begin bad++; $display("[TB] FAIL reset_outstanding got=%0d want=0", outstanding); end
        rst = 1'b0;
        prep();
        total++; if (s_lookup_ready !== 1'b0 || s_update_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_readies got=%0b%0b want=00", s_lookup_ready, s_update_ready);
        end
        tick();
    endtask

    // Both streams always valid: four updates then one lookup, repeating.
    task automatic test_priority();
        do_reset();
        s_lookup_valid = 1'b1; s_update_valid = 1'b1; m_cmd_ready = 1'b1; rsp_fire = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_lookup_index = KEY_SIZE'($urandom); s_update_index = KEY_SIZE'($urandom);
            s_update_data = $urandom;
            prep(); tick();
            total++; if (m_cmd_valid !== 1'b1 || m_cmd_op !== ((i % 5 == 4) ? 1'b0 : 1'b1)) begin
                bad++; $display("[TB] FAIL priority_op[%0d] got=v%0b/op%0b want=v1/op%0b", i, m_cmd_valid, m_cmd_op, (i % 5 == 4) ? 1'b0 : 1'b1);
            end
        end
        set_idle();
    endtask

    task automatic test_outstanding_cap();
        int accepted;
        do_reset();
        s_lookup_valid = 1'b1; m_cmd_ready = 1'b1;
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            s_lookup_index = KEY_SIZE'(i);
            prep();
            if (s_lookup_ready === 1'b1) accepted++;
            tick();
        end
        total++; if (accepted != 4) begin bad++; $display("[TB] FAIL cap_accepted got=%0d want=4", accepted); end
        total++; if (outstanding !== 3'd4) begin bad++; $display("[TB] FAIL cap_outstanding got=%0d want=4", outstanding); end
        prep();
        total++; if (s_lookup_ready !== 1'b0) begin bad++; $display("[TB] FAIL cap_ready_low got=%0b want=0", s_lookup_ready); end
        rsp_fire = 1'b1;
        prep();
        total++; if (s_lookup_ready !== 1'b0) begin bad++; $display("[TB] FAIL cap_no_bypass got=%0b want=0", s_lookup_ready); end
        tick();
        rsp_fire = 1'b0;
        accepted = 0;
        for (int i = 0; i < 4; i++) begin
            prep();
            if (s_lookup_ready === 1'b1) accepted++;
            tick();
        end
        total++; if (accepted != 1) begin bad++; $display("[TB] FAIL cap_refill got=%0d want=1", accepted); end
        total++; if (outstanding !== 3'd4) begin bad++; $display("[TB] FAIL cap_refill_out got=%0d want=4", outstanding); end
        set_idle();
    endtask

    task automatic test_backpressure();
        do_reset();
        s_update_valid = 1'b1; s_update_index = 8'h12; s_update_data = 32'hDEADBEEF; s_update_user = 4'h5;
        prep(); tick();
        s_update_index = 8'h34; s_update_data = 32'hCAFEF00D; s_update_user = 4'h9;
        for (int i = 0; i < 3; i++) begin
            total++; if (m_cmd_valid !== 1'b1 || m_cmd_op !== 1'b1 || m_cmd_index !== 8'h12 ||
                         m_cmd_data !== 32'hDEADBEEF || m_cmd_user !== 4'h5) begin
                bad++; $display("[TB] FAIL bp_hold[%0d] got=v%0b op%0b %0h/%0h/%0h want=v1 op1 12/deadbeef/5",
                                i, m_cmd_valid, m_cmd_op, m_cmd_index, m_cmd_data, m_cmd_user);
            end
            prep();
            total++; if (s_lookup_ready !== 1'b0 || s_update_ready !== 1'b0) begin
                bad++; $display("[TB] FAIL bp_readies[%0d] got=%0b%0b want=00", i, s_lookup_ready, s_update_ready);
            end
            tick();
        end
        m_cmd_ready = 1'b1;
        prep();
        total++; if (s_update_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_ready got=%0b want=1", s_update_ready); end
        tick();
        total++; if (m_cmd_valid !== 1'b1 || m_cmd_index !== 8'h34 || m_cmd_data !== 32'hCAFEF00D || m_cmd_user !== 4'h9) begin
            bad++; $display("[TB] FAIL bp_next got=v%0b %0h/%0h/%0h want=v1 34/cafef00d/9", m_cmd_valid, m_cmd_index, m_cmd_data, m_cmd_user);
        end
        set_idle();
    endtask

    task automatic test_flush();
        do_reset();
        s_lookup_valid = 1'b1; m_cmd_ready = 1'b1;
        prep(); tick();
        prep(); tick();
        s_lookup_valid = 1'b0;
        prep(); tick();
        flush_req = 1'b1;
        prep(); tick();
        flush_req = 1'b0;
        s_lookup_valid = 1'b1; s_update_valid = 1'b1;
        total++; if (outstanding !== 3'd2) begin bad++; $display("[TB] FAIL flush_start_out got=%0d want=2", outstanding); end
        for (int i = 0; i < 2; i++) begin
            rsp_fire = 1'b1;
            prep();
            total++; if (s_lookup_ready !== 1'b0 || s_update_ready !== 1'b0) begin
                bad++; $display("[TB] FAIL flush_drain_readies[%0d] got=%0b%0b want=00", i, s_lookup_ready, s_update_ready);
            end
            tick();
        end
        rsp_fire = 1'b0;
        total++; if (outstanding !== '0 || flush_done !== 1'b0) begin
            bad++; $display("[TB] FAIL flush_drained got=out%0d/done%0b want=out0/done0", outstanding, flush_done);
        end
        prep(); tick();
        total++; if (flush_done !== 1'b1) begin bad++; $display("[TB] FAIL flush_done_pulse got=%0b want=1", flush_done); end
        prep();
        total++; if (s_lookup_ready !== 1'b0 || s_update_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL flush_done_readies got=%0b%0b want=00", s_lookup_ready, s_update_ready);
        end
        tick();
        total++; if (flush_done !== 1'b0) begin bad++; $display("[TB] FAIL flush_done_once got=%0b want=0", flush_done); end
        prep();
        total++; if (s_update_ready !== 1'b1 || s_lookup_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL flush_resume got=%0b%0b want=01", s_lookup_ready, s_update_ready);
        end
        tick();
        set_idle();
    endtask

    task automatic test_reset_midop();
        do_reset();
        s_lookup_valid = 1'b1; m_cmd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            prep(); tick();
        end
        total++; if (m_cmd_valid !== 1'b1 || outstanding !== 3'd3) begin
            bad++; $display("[TB] FAIL midop_pre got=v%0b/out%0d want=v1/out3", m_cmd_valid, outstanding);
        end
        rst = 1'b1; m_cmd_ready = 1'b0;
        prep(); tick();
        rst = 1'b0;
        total++; if (m_cmd_valid !== 1'b0 || outstanding !== '0 || flush_done !== 1'b0) begin
            bad++; $display("[TB] FAIL midop_reset got=v%0b/out%0d/done%0b want=v0/out0/done0", m_cmd_valid, outstanding, flush_done);
        end
        prep();
        total++; if (s_lookup_ready !== 1'b1) begin bad++; $display("[TB] FAIL midop_run got=%0b want=1", s_lookup_ready); end
        tick();
        set_idle();
    endtask

    task automatic test_rsp_underflow();
        do_reset();
        rsp_fire = 1'b1;
        prep(); tick();
        total++; if (outstanding !== '0) begin bad++; $display("[TB] FAIL underflow_zero got=%0d want=0", outstanding); end
        s_lookup_valid = 1'b1; m_cmd_ready = 1'b1;
        prep(); tick();
        total++; if (outstanding !== 3'd1) begin bad++; $display("[TB] FAIL underflow_accept got=%0d want=1", outstanding); end
        set_idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst            = ($urandom_range(0, 149) == 0);
            s_lookup_valid = ($urandom_range(0, 2) != 0);
            s_update_valid = ($urandom_range(0, 1) != 0);
            s_lookup_index = KEY_SIZE'($urandom);
            s_lookup_user  = USER_WIDTH'($urandom);
            s_update_index = KEY_SIZE'($urandom);
            s_update_data  = $urandom;
            s_update_user  = USER_WIDTH'($urandom);
            m_cmd_ready    = ($urandom_range(0, 3) != 0);
            rsp_fire       = ($urandom_range(0, 2) == 0);
            flush_req      = ($urandom_range(0, 29) == 0);
            prep();
            total++; if (s_lookup_ready !== exp_lr || s_update_ready !== exp_ur) begin
                bad++; $display("[TB] FAIL rand_readies[%0d] got=%0b%0b want=%0b%0b", i, s_lookup_ready, s_update_ready, exp_lr, exp_ur);
            end
            tick();
            total++; if (m_cmd_valid !== m_valid) begin
                bad++; $display("[TB] FAIL rand_valid[%0d] got=%0b want=%0b", i, m_cmd_valid, m_valid);
            end
            if (m_valid) begin
                total++; if (m_cmd_op !== m_op || m_cmd_index !== m_index || m_cmd_data !== m_data || m_cmd_user !== m_user) begin
                    bad++; $display("[TB] FAIL rand_payload[%0d] got=%0b/%0h/%0h/%0h want=%0b/%0h/%0h/%0h",
                                    i, m_cmd_op, m_cmd_index, m_cmd_data, m_cmd_user, m_op, m_index, m_data, m_user);
                end
            end
            total++; if (outstanding !== OUT_W'(m_out)) begin
                bad++; $display("[TB] FAIL rand_outstanding[%0d] got=%0d want=%0d", i, outstanding, m_out);
            end
            total++; if (flush_done !== m_done) begin
                bad++; $display("[TB] FAIL rand_flush_done[%0d] got=%0b want=%0b", i, flush_done, m_done);
            end
        end
        rst = 1'b0;
        set_idle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        set_idle();
        m_phase = 0; m_starve = 0; m_out = 0; m_valid = 1'b0; m_op = 1'b0;
        m_index = '0; m_data = '0; m_user = '0; m_done = 1'b0;
        test_reset();
        test_priority();
        test_outstanding_cap();
        test_backpressure();
        test_flush();
        test_reset_midop();
        test_rsp_underflow();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
